// File: rtl/rotate_issue_stage_if.sv
// Command/result handshake bundle for rotate_issue_stage.
// The master side produces rotate commands and consumes results; the slave side
// is the issue stage itself.
interface rotate_issue_stage_if #(
  parameter int DATA_W = 16,
  parameter int AMT_W  = 4
);
  // Command channel
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_data;
  logic [AMT_W-1:0]  in_amt;
  logic              in_left;

  // Result channel
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_data;

  modport master (
    output in_valid, in_data, in_amt, in_left, out_ready,
    input  in_ready, out_valid, out_data
  );

  modport slave (
    input  in_valid, in_data, in_amt, in_left, out_ready,
    output in_ready, out_valid, out_data
  );
endinterface

// File: rtl/rotate_issue_stage.sv
// Sequential front/back end for a combinational rotator: a small command FIFO
// feeds the rotator from its head entry and a registered valid/ready output stage
// captures the rotator result, giving a back-pressurable one-result-per-cycle unit.
module rotate_issue_stage #(
  parameter int DATA_W = 16,
  parameter int AMT_W  = 4,
  parameter int DEPTH  = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  rotate_issue_stage_if.slave      bus,
  output logic [DATA_W-1:0]        rot_a,
  output logic [AMT_W-1:0]         rot_k,
  output logic                     rot_left,
  input  logic [DATA_W-1:0]        rot_y,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  typedef struct packed {
    logic [DATA_W-1:0] data;
    logic [AMT_W-1:0]  amt;
    logic              left;
  } cmd_t;

  cmd_t              mem [DEPTH];
  cmd_t              head;
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic              push;
  logic              pop;
  logic              not_empty;
  logic              out_valid_q;
  logic [DATA_W-1:0] out_data_q;

  // NOTE: in_ready is a function of registered occupancy only, so a full FIFO never
  // accepts a command in the same cycle it pops one; this keeps in_ready free of any
  // combinational path from out_ready.
  assign bus.in_ready = rst_n && (count != CNT_W'(DEPTH));
  assign not_empty    = (count != '0);
  assign push         = bus.in_valid && bus.in_ready;
  assign pop          = not_empty && (!out_valid_q || bus.out_ready);

  // Head entry drives the rotator directly; an empty FIFO presents all zeros.
  assign head     = mem[rd_ptr];
  assign rot_a    = not_empty ? head.data : '0;
  assign rot_k    = not_empty ? head.amt  : '0;
  assign rot_left = not_empty ? head.left : 1'b0;

  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = out_data_q;

  // Command storage write on accept.
  // NOTE: the storage array carries no reset; occupancy and pointers alone decide
  // which entries are live, so stale contents after reset are never observed.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= '{data: bus.in_data, amt: bus.in_amt, left: bus.in_left};
    end
  end

  // Pointer and occupancy bookkeeping; pointers wrap naturally because DEPTH is 2^n.
  // NOTE: all sequential state uses non-blocking assignment so every register in the
  // block samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  // Output register: capture the rotator result on pop, drop valid once consumed.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
    end else if (pop) begin
      out_valid_q <= 1'b1;
      out_data_q  <= rot_y;
    end else if (out_valid_q && bus.out_ready) begin
      out_valid_q <= 1'b0;
    end
  end

endmodule

// File: tb/tb_rotate_issue_stage.sv
// Directed bench for rotate_issue_stage with a behavioural 16-bit rotator wired
// to the rot_* port group. Inputs are driven and outputs sampled on the falling edge.
module tb_rotate_issue_stage;

  logic        clk;
  logic        rst_n;
  logic [15:0] rot_a;
  logic [3:0]  rot_k;
  logic        rot_left;
  logic [15:0] rot_y;
  logic [2:0]  count;

  int checks;
  int failures;

  rotate_issue_stage_if #(.DATA_W(16), .AMT_W(4)) bus ();

  rotate_issue_stage #(.DATA_W(16), .AMT_W(4), .DEPTH(4)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .bus      (bus),
    .rot_a    (rot_a),
    .rot_k    (rot_k),
    .rot_left (rot_left),
    .rot_y    (rot_y),
    .count    (count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural rotator: one bit position per iteration.
  function automatic logic [15:0] rot_model(logic [15:0] a, logic [3:0] k, logic l);
    logic [15:0] r;
    r = a;
    for (int i = 0; i < int'(k); i++) begin
      r = l ? {r[14:0], r[15]} : {r[0], r[15:1]};
    end
    return r;
  endfunction

  always_comb rot_y = rot_model(rot_a, rot_k, rot_left);

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic drive(input logic v, input logic [15:0] d, input logic [3:0] a, input logic l);
    bus.in_valid = v;
    bus.in_data  = d;
    bus.in_amt   = a;
    bus.in_left  = l;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  // Command tables for the back-pressure and continuous-stream steps.
  logic [15:0] bp_data [7];
  logic [3:0]  bp_amt  [7];
  logic        bp_left [7];
  logic [15:0] bp_exp  [5];

  initial begin
    int k;
    logic [15:0] e;
    checks   = 0;
    failures = 0;
    rst_n    = 1'b0;
    bus.out_ready = 1'b0;
    drive(1'b0, 16'h0, 4'h0, 1'b0);

    bp_data = '{16'h0001, 16'h0001, 16'h8000, 16'h00F0, 16'hF000, 16'hDEAD, 16'hBEEF};
    bp_amt  = '{4'd0, 4'd1, 4'd1, 4'd4, 4'd15, 4'd3, 4'd5};
    bp_left = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
    bp_exp  = '{16'h0001, 16'h0002, 16'h4000, 16'h000F, 16'h7800};

    // ---- Reset and release ----
    @(negedge clk);
    @(negedge clk);
    check("in_ready_in_reset", 32'(bus.in_ready), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    check("rst_in_ready",  32'(bus.in_ready),  32'd1);
    check("rst_out_valid", 32'(bus.out_valid), 32'd0);
    check("rst_out_data",  32'(bus.out_data),  32'd0);
    check("rst_count",     32'(count),         32'd0);
    check("rst_rot_a",     32'(rot_a),         32'd0);
    check("rst_rot_k",     32'(rot_k),         32'd0);
    check("rst_rot_left",  32'(rot_left),      32'd0);

    // ---- Single command, latency ----
    bus.out_ready = 1'b1;
    drive(1'b1, 16'h8001, 4'd1, 1'b1);
    @(negedge clk);
    drive(1'b0, 16'h0, 4'h0, 1'b0);
    check("single_count_1",   32'(count),         32'd1);
    check("single_out_valid0",32'(bus.out_valid), 32'd0);
    check("single_head_a",    32'(rot_a),         32'h8001);
    check("single_head_k",    32'(rot_k),         32'd1);
    check("single_head_left", 32'(rot_left),      32'd1);
    @(negedge clk);
    check("single_out_valid", 32'(bus.out_valid), 32'd1);
    check("single_out_data",  32'(bus.out_data),  32'h0003);
    check("single_count_0",   32'(count),         32'd0);
    @(negedge clk);
    check("single_drained",   32'(bus.out_valid), 32'd0);

    // ---- Three back-to-back commands ----
    drive(1'b1, 16'h1234, 4'd4, 1'b0);
    @(negedge clk);
    drive(1'b1, 16'h1234, 4'd4, 1'b1);
    @(negedge clk);
    check("b2b_v0", 32'(bus.out_valid), 32'd1);
    check("b2b_d0", 32'(bus.out_data),  32'h4123);
    drive(1'b1, 16'h1234, 4'd0, 1'b1);
    @(negedge clk);
    drive(1'b0, 16'h0, 4'h0, 1'b0);
    check("b2b_v1", 32'(bus.out_valid), 32'd1);
    check("b2b_d1", 32'(bus.out_data),  32'h2341);
    @(negedge clk);
    check("b2b_v2", 32'(bus.out_valid), 32'd1);
    check("b2b_d2", 32'(bus.out_data),  32'h1234);
    @(negedge clk);
    check("b2b_idle", 32'(bus.out_valid), 32'd0);
    check("b2b_count", 32'(count), 32'd0);

    // ---- Back-pressure: offer 7 commands over 7 cycles, hold until accepted ----
    bus.out_ready = 1'b0;
    k = 0;
    for (int c = 0; c < 7; c++) begin
      drive(1'b1, bp_data[k], bp_amt[k], bp_left[k]);
      if (bus.in_ready) k++;
      @(negedge clk);
    end
    drive(1'b0, 16'h0, 4'h0, 1'b0);
    check("bp_accepted",  32'(k),             32'd5);
    check("bp_count",     32'(count),         32'd4);
    check("bp_in_ready",  32'(bus.in_ready),  32'd0);
    check("bp_out_valid", 32'(bus.out_valid), 32'd1);
    @(negedge clk);
    check("bp_held_data", 32'(bus.out_data),  32'h0001);
    bus.out_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      check($sformatf("bp_v%0d", i), 32'(bus.out_valid), 32'd1);
      check($sformatf("bp_d%0d", i), 32'(bus.out_data),  32'(bp_exp[i]));
      @(negedge clk);
    end
    check("bp_drained", 32'(bus.out_valid), 32'd0);
    check("bp_count0",  32'(count),         32'd0);

    // ---- Continuous stream of 16 commands, out_ready held high ----
    // Even i: rotl(i,4) = i<<4; odd i: rotr(i,4) = i<<12 (i < 16 so no bits wrap).
    for (int t = 0; t < 18; t++) begin
      if (t < 16) drive(1'b1, 16'(t), 4'd4, (t % 2) == 0);
      else        drive(1'b0, 16'h0, 4'h0, 1'b0);
      if (t >= 2) begin
        e = ((t - 2) % 2 == 0) ? 16'((t - 2) << 4) : 16'((t - 2) << 12);
        check($sformatf("stream_v%0d", t - 2), 32'(bus.out_valid), 32'd1);
        check($sformatf("stream_d%0d", t - 2), 32'(bus.out_data),  32'(e));
      end
      if (t >= 1 && t <= 16) check($sformatf("stream_count%0d", t), 32'(count), 32'd1);
      @(negedge clk);
    end
    check("stream_drained", 32'(bus.out_valid), 32'd0);
    check("stream_count0",  32'(count),         32'd0);

    // ---- Asynchronous reset mid-stream ----
    bus.out_ready = 1'b0;
    drive(1'b1, 16'hAAAA, 4'd1, 1'b1);
    @(negedge clk);
    drive(1'b1, 16'hBBBB, 4'd2, 1'b0);
    @(negedge clk);
    drive(1'b1, 16'hCCCC, 4'd3, 1'b1);
    @(negedge clk);
    drive(1'b1, 16'hDDDD, 4'd4, 1'b0);
    @(negedge clk);
    drive(1'b0, 16'h0, 4'h0, 1'b0);
    check("mid_count3",     32'(count),         32'd3);
    check("mid_out_valid1", 32'(bus.out_valid), 32'd1);
    check("mid_out_data",   32'(bus.out_data),  32'h5555);
    #2 rst_n = 1'b0;
    #1;
    check("async_out_valid", 32'(bus.out_valid), 32'd0);
    check("async_count",     32'(count),         32'd0);
    check("async_in_ready",  32'(bus.in_ready),  32'd0);
    check("async_out_data",  32'(bus.out_data),  32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    bus.out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check($sformatf("post_rst_idle%0d", i), 32'(bus.out_valid), 32'd0);
    end
    check("post_rst_rot_a", 32'(rot_a), 32'd0);
    drive(1'b1, 16'h1234, 4'd8, 1'b1);
    @(negedge clk);
    drive(1'b0, 16'h0, 4'h0, 1'b0);
    @(negedge clk);
    check("post_rst_valid", 32'(bus.out_valid), 32'd1);
    check("post_rst_data",  32'(bus.out_data),  32'h3412);
    @(negedge clk);
    check("post_rst_done",  32'(bus.out_valid), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
